// File: rtl/peripheral_uart_wb_ctrl.sv
// Wishbone master that initialises a 16550-style UART, then polls LSR
// and moves bytes between it and two TX requesters / one RX consumer.
module peripheral_uart_wb_ctrl #(
  parameter logic [15:0] DIVISOR  = 16'd27,
  parameter logic [7:0]  LCR_VAL  = 8'h03,
  parameter int          TX_BURST = 16,
  parameter int          TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  output logic [3:0] wbm_sel_o,
  input  logic       wbm_ack_i,
  input  logic [7:0] tx0_data_i,
  input  logic       tx0_valid_i,
  output logic       tx0_ready_o,
  input  logic [7:0] tx1_data_i,
  input  logic       tx1_valid_i,
  output logic       tx1_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic [7:0] lsr_o,
  output logic       init_done_o,
  output logic       timeout_o
);
  localparam logic [4:0]  BURST    = 5'(TX_BURST);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT, S_POLL, S_RX, S_TX
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [15:0] tmo_q, tmo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        rr_q, rr_d;
  logic        rxv_q, rxv_d;
  logic [7:0]  rxd_q, rxd_d;
  logic [7:0]  lsr_q, lsr_d;
  logic        done_q, done_d;
  logic        tflag_q, tflag_d;

  logic        ack, expire, gnt_valid;
  logic [7:0]  gnt_data;
  logic [2:0]  init_adr;
  logic [7:0]  init_dat;

  assign ack       = stb_q & wbm_ack_i;
  assign expire    = stb_q & ~wbm_ack_i
                   & (tmo_q == TMO_LAST);
  assign gnt_valid = gnt_q ? tx1_valid_i : tx0_valid_i;
  assign gnt_data  = gnt_q ? tx1_data_i : tx0_data_i;

  always_comb begin
    init_adr = 3'd1;
    init_dat = 8'h00;
    case (step_q)
      3'd0: begin
        init_adr = 3'd3;
        init_dat = LCR_VAL | 8'h80;
      end
      3'd1: begin
        init_adr = 3'd0;
        init_dat = DIVISOR[7:0];
      end
      3'd2: begin
        init_adr = 3'd1;
        init_dat = DIVISOR[15:8];
      end
      3'd3: begin
        init_adr = 3'd3;
        init_dat = LCR_VAL;
      end
      3'd4: begin
        init_adr = 3'd2;
        init_dat = 8'h07;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    rxv_d   = rxv_q;
    rxd_d   = rxd_q;
    lsr_d   = lsr_q;
    done_d  = done_q;
    tflag_d = tflag_q;
    if (rxv_q && rx_ready_i) rxv_d = 1'b0;
    if (!stb_q) begin
      // idle cycle: launch the next access
      tmo_d = '0;
      unique case (state_q)
        S_INIT: begin
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = init_adr;
          dat_d = init_dat;
        end
        S_POLL: begin
          stb_d = 1'b1;
          we_d  = 1'b0;
          adr_d = 3'd5;
          dat_d = 8'h00;
        end
        S_RX: begin
          stb_d = 1'b1;
          we_d  = 1'b0;
          adr_d = 3'd0;
          dat_d = 8'h00;
        end
        S_TX: begin
          if (cnt_q < BURST && gnt_valid) begin
            stb_d = 1'b1;
            we_d  = 1'b1;
            adr_d = 3'd0;
            dat_d = gnt_data;
          end else begin
            cnt_d   = '0;
            rr_d    = ~gnt_q;
            state_d = S_POLL;
          end
        end
      endcase
    end else if (ack || expire) begin
      stb_d = 1'b0;
      if (expire) tflag_d = 1'b1;
      unique case (state_q)
        S_INIT: begin
          step_d = step_q + 3'd1;
          if (step_q == 3'd5) begin
            state_d = S_POLL;
            done_d  = 1'b1;
          end
        end
        S_POLL: begin
          if (ack) begin
            lsr_d = wbm_dat_i;
            if (wbm_dat_i[0] && !rxv_q) begin
              state_d = S_RX;
            end else if (wbm_dat_i[5] &&
                (tx0_valid_i || tx1_valid_i)) begin
              state_d = S_TX;
              gnt_d = (tx0_valid_i && tx1_valid_i)
                    ? rr_q : tx1_valid_i;
            end
          end
        end
        S_RX: begin
          if (ack) begin
            rxd_d = wbm_dat_i;
            rxv_d = 1'b1;
          end
          state_d = S_POLL;
        end
        S_TX: begin
          if (ack) begin
            cnt_d = cnt_q + 5'd1;
          end else begin
            cnt_d   = '0;
            rr_d    = ~gnt_q;
            state_d = S_POLL;
          end
        end
      endcase
    end else begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      step_q  <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
      rxv_q   <= 1'b0;
      rxd_q   <= '0;
      lsr_q   <= '0;
      done_q  <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
      lsr_q   <= lsr_d;
      done_q  <= done_d;
      tflag_q <= tflag_d;
    end
  end

  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_we_o    = we_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_cyc_o   = stb_q;
  assign wbm_sel_o   = {3'b000, stb_q};
  assign tx0_ready_o = ack & (state_q == S_TX) & ~gnt_q;
  assign tx1_ready_o = ack & (state_q == S_TX) & gnt_q;
  assign rx_data_o   = rxd_q;
  assign rx_valid_o  = rxv_q;
  assign lsr_o       = lsr_q;
  assign init_done_o = done_q;
  assign timeout_o   = tflag_q;
endmodule
